// File: rtl/sha256_job_arbiter.sv
// Round-robin job scheduler sharing one simplified_sha256 core among NUM_REQ requesters.
// Sequences the core start/done handshake, returns per-requester done/err pulses, and aborts hung jobs.
module sha256_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_message_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_output_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        job_done,
    output logic [NUM_REQ-1:0]        job_err,
    output logic                      busy,
    output logic                      core_start,
    output logic [ADDR_W-1:0]         core_message_addr,
    output logic [ADDR_W-1:0]         core_output_addr,
    output logic                      core_reset_n,
    input  logic                      core_done
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DONE,
        ABORT
    } state_t;

    state_t              state_reg, state_next;
    logic [PTR_W-1:0]    ptr_reg, ptr_next;
    logic [PTR_W-1:0]    gidx_reg, gidx_next;
    logic [NUM_REQ-1:0]  grant_reg, grant_next;
    logic [ADDR_W-1:0]   msg_reg, msg_next;
    logic [ADDR_W-1:0]   out_reg, out_next;
    logic [WD_W-1:0]     wd_reg, wd_next;
    logic                abort_tail_reg, abort_tail_next;

    logic [PTR_W-1:0]    cand [NUM_REQ];
    logic [ADDR_W-1:0]   msg_slice [NUM_REQ];
    logic [ADDR_W-1:0]   out_slice [NUM_REQ];
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [WD_W-1:0]     wd_inc;
    logic                timeout_hit;
    logic [PTR_W-1:0]    ptr_adv;

    // cand[k] is the requester examined k-th in this round, starting at the pointer
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [PTR_W:0] sum;
            assign sum = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign cand[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                              PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : sum[PTR_W-1:0];
            assign msg_slice[gi] = req_message_addr[gi*ADDR_W +: ADDR_W];
            assign out_slice[gi] = req_output_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[cand[k]]) begin
                win_found = 1'b1;
                win_idx   = cand[k];
            end
        end
    end

    assign wd_inc      = (wd_reg == '1) ? wd_reg : wd_reg + WD_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_reg == WD_LAST);
    assign ptr_adv     = (gidx_reg == PTR_MAX) ? '0 : gidx_reg + PTR_W'(1);

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        gidx_next       = gidx_reg;
        grant_next      = grant_reg;
        msg_next        = msg_reg;
        out_next        = out_reg;
        wd_next         = wd_reg;
        abort_tail_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (core_done && win_found) begin
                    state_next = START;
                    gidx_next  = win_idx;
                    grant_next = NUM_REQ'(1) << win_idx;
                    msg_next   = msg_slice[win_idx];
                    out_next   = out_slice[win_idx];
                    wd_next    = '0;
                end
            end
            START: begin
                wd_next = wd_inc;
                if (timeout_hit) begin
                    state_next = ABORT;
                end else if (!core_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // a finished hash wins over a watchdog expiring in the same cycle
                wd_next = wd_inc;
                if (core_done) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = ABORT;
                end
            end
            DONE: begin
                state_next = IDLE;
                grant_next = '0;
                ptr_next   = ptr_adv;
            end
            ABORT: begin
                if (!abort_tail_reg) begin
                    abort_tail_next = 1'b1;
                end else begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = ptr_adv;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            gidx_reg       <= '0;
            grant_reg      <= '0;
            msg_reg        <= '0;
            out_reg        <= '0;
            wd_reg         <= '0;
            abort_tail_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            gidx_reg       <= gidx_next;
            grant_reg      <= grant_next;
            msg_reg        <= msg_next;
            out_reg        <= out_next;
            wd_reg         <= wd_next;
            abort_tail_reg <= abort_tail_next;
        end
    end

    assign grant             = grant_reg;
    assign busy              = (state_reg != IDLE);
    assign core_start        = (state_reg == START);
    assign core_message_addr = msg_reg;
    assign core_output_addr  = out_reg;
    assign job_done          = (state_reg == DONE) ? grant_reg : '0;
    assign job_err           = (state_reg == ABORT && !abort_tail_reg) ? grant_reg : '0;
    // the core stays in reset alongside us and for both abort cycles
    assign core_reset_n      = !reset && (state_reg != ABORT);

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Bench for sha256_job_arbiter: directed scenarios plus random jobs against a stub core
// and a round-robin/timing reference model.
module tb_sha256_job_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int TO = 50;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*AW-1:0]  req_message_addr;
    logic [N*AW-1:0]  req_output_addr;
    logic [N-1:0]     grant;
    logic [N-1:0]     job_done;
    logic [N-1:0]     job_err;
    logic             busy;
    logic             core_start;
    logic [AW-1:0]    core_message_addr;
    logic [AW-1:0]    core_output_addr;
    logic             core_reset_n;
    logic             core_done;

    always #5 clk = ~clk;

    sha256_job_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_message_addr(req_message_addr), .req_output_addr(req_output_addr),
        .grant(grant), .job_done(job_done), .job_err(job_err), .busy(busy),
        .core_start(core_start), .core_message_addr(core_message_addr),
        .core_output_addr(core_output_addr), .core_reset_n(core_reset_n),
        .core_done(core_done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub core: done is high while idle; start in idle makes it busy for stub_lat cycles
    logic stub_busy = 1'b0;
    int   stub_cnt  = 0;
    int   stub_lat  = 5;
    logic stub_hang = 1'b0;
    logic hold_busy = 1'b0;

    always @(posedge clk) begin
        if (!core_reset_n) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
        end else if (!stub_busy) begin
            if (core_start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= stub_lat;
            end
        end else if (!stub_hang) begin
            if (stub_cnt <= 1) stub_busy <= 1'b0;
            else stub_cnt <= stub_cnt - 1;
        end
    end
    assign core_done = !stub_busy && !hold_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_p  = 0;
    int last_gcyc, last_ecyc;
    int tally [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_pulses"}, {job_done, job_err}, 0);
        chk({tag, "_busy_start"}, {busy, core_start}, 0);
        chk({tag, "_addrs"}, {core_message_addr, core_output_addr}, 0);
        chk({tag, "_core_reset_n"}, core_reset_n, 0);
    endtask

    // Runs one job from an IDLE negedge to the IDLE negedge after it; returns granted index
    task automatic run_job(input int lat, input bit hang, input bit drop_mid, input bit keep,
                           output int g);
        logic [N-1:0]  snap;
        logic [N-1:0]  pval;
        logic [AW-1:0] exp_msg, exp_out;
        int gcyc, waited, pcyc, ndone, nerr, starts, rn_low, ecyc;
        stub_lat  = lat;
        stub_hang = hang;
        snap = req;
        g = rr_pick(snap, model_p);
        exp_msg = req_message_addr[g*AW +: AW];
        exp_out = req_output_addr[g*AW +: AW];
        gcyc = -1;
        waited = 0;
        for (int w = 0; w < 64 && gcyc < 0; w++) begin
            @(negedge clk);
            waited = w;
            if (grant != '0) gcyc = cyc;
        end
        if (gcyc < 0) begin
            chk("grant_seen", {63'b0, grant != '0}, 64'd1);
            return;
        end
        chk("issue_latency", waited, 0);
        chk("grant_onehot", grant, 64'd1 << g);
        chk("msg_addr", core_message_addr, exp_msg);
        chk("out_addr", core_output_addr, exp_out);
        chk("busy_run", busy, 1);
        starts = core_start ? 1 : 0;
        // later address changes must not reach the core
        req_message_addr = {$urandom, $urandom};
        req_output_addr  = {$urandom, $urandom};
        if (drop_mid) req[g] = 1'b0;
        ndone = 0; nerr = 0; pcyc = -1; pval = '0; rn_low = 0; ecyc = -1;
        for (int w = 0; w < 200 && ecyc < 0; w++) begin
            @(negedge clk);
            if (core_start) starts++;
            if (!core_reset_n) rn_low++;
            if (job_done != '0) begin
                ndone++; pval = job_done; pcyc = cyc;
                chk("addr_hold", {core_message_addr, core_output_addr}, {exp_msg, exp_out});
            end
            if (job_err != '0) begin
                nerr++; pval = job_err; pcyc = cyc;
            end
            if ((job_done != '0 || job_err != '0) && !keep) req[g] = 1'b0;
            if (grant == '0) ecyc = cyc;
        end
        chk("start_cycles", starts, 2);
        chk("pulse_value", pval, 64'd1 << g);
        if (!hang) begin
            chk("done_count", ndone, 1);
            chk("err_count", nerr, 0);
            chk("done_cycle", pcyc, gcyc + lat + 2);
            chk("idle_cycle", ecyc, pcyc + 1);
            chk("reset_n_high", rn_low, 0);
        end else begin
            chk("err_count", nerr, 1);
            chk("done_count", ndone, 0);
            chk("err_cycle", pcyc, gcyc + TO);
            chk("abort_reset_n_low", rn_low, 2);
            chk("idle_cycle", ecyc, pcyc + 2);
        end
        chk("busy_idle", busy, 0);
        $display("job req=%b g=%0d lat=%0d hang=%0d grant_cyc=%0d pulse_cyc=%0d", snap, g, lat,
                 hang, gcyc, pcyc);
        model_p   = (g + 1) % N;
        last_gcyc = gcyc;
        last_ecyc = ecyc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_p = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int prev_e;
        int pair_exp [3];
        reset = 1'b1;
        req = '0;
        req_message_addr = '0;
        req_output_addr = '0;
        pair_exp = '{0, 3, 0};
        for (int i = 0; i < N; i++) tally[i] = 0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // single job on requester 2
        req_message_addr = {$urandom, $urandom};
        req_output_addr  = {$urandom, $urandom};
        req_message_addr[2*AW +: AW] = 16'h0000;
        req_output_addr[2*AW +: AW]  = 16'h0100;
        req = 4'b0100;
        run_job($urandom_range(3, 20), 1'b0, 1'b0, 1'b0, g);
        chk("single_g", g, 2);

        // simultaneous pair held from reset release
        do_reset();
        req = 4'b1001;
        reset = 1'b0;
        prev_e = -1;
        for (int j = 0; j < 3; j++) begin
            run_job($urandom_range(1, 20), 1'b0, 1'b0, 1'b1, g);
            chk("pair_order", g, pair_exp[j]);
            if (j > 0) chk("pair_gap", last_gcyc - prev_e, 1);
            prev_e = last_ecyc;
        end
        req = '0;

        // fairness over 8 jobs
        do_reset();
        req = 4'b1111;
        reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(1, 20), 1'b0, 1'b0, 1'b1, g);
            chk("fair_order", g, j % N);
            if (j > 0) chk("fair_gap", last_gcyc - prev_e, 1);
            prev_e = last_ecyc;
            tally[g]++;
        end
        req = '0;
        for (int i = 0; i < N; i++) chk("fair_tally", tally[i], 2);

        // hung core -> watchdog abort
        req = 4'b0010;
        run_job(5, 1'b1, 1'b0, 1'b0, g);

        // reset 30 cycles into RUN
        req = 4'b0100;
        stub_lat = 45;
        stub_hang = 1'b0;
        g = 0;
        for (int w = 0; w < 64 && g == 0; w++) begin
            @(negedge clk);
            if (grant != '0) g = 1;
        end
        chk("midreset_grant", grant, 4'b0100);
        for (int w = 0; w < 32; w++) begin
            @(negedge clk);
            chk("midreset_no_pulse", {job_done, job_err}, 0);
        end
        reset = 1'b1;
        #1;
        chk("midreset_core_reset_n", core_reset_n, 0);
        req = 4'b0010;
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(negedge clk);
        model_p = 0;
        reset = 1'b0;
        run_job($urandom_range(1, 20), 1'b0, 1'b0, 1'b0, g);
        chk("after_reset_g", g, 1);

        // request dropped mid-job still completes
        req = 4'b0001;
        run_job($urandom_range(1, 20), 1'b0, 1'b1, 1'b0, g);

        // core not idle: nothing issues until core_done rises
        hold_busy = 1'b1;
        req = 4'b1000;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            chk("hold_no_issue", {grant, busy, core_start}, 0);
        end
        hold_busy = 1'b0;
        run_job($urandom_range(1, 20), 1'b0, 1'b0, 1'b0, g);

        // random jobs
        for (int j = 0; j < 24; j++) begin
            req = 4'($urandom_range(1, 15));
            req_message_addr = {$urandom, $urandom};
            req_output_addr  = {$urandom, $urandom};
            run_job($urandom_range(1, 20), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                    1'b0, g);
        end
        req = '0;
        repeat (3) @(negedge clk);
        chk("final_idle", {grant, busy, job_done, job_err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
